// File: rtl/fcl_loader_pkg.sv
// defs: field geometry, load request type and built-in start patterns
package defs;
  localparam int FIELD_W = 16;
  localparam int FIELD_H = 16;
  typedef enum logic [1:0] {NO_REQ, CFG_1, CFG_2} load_cfg_req_t;
  localparam logic [15:0] GLIDER_R1  = 16'h0004;
  localparam logic [15:0] GLIDER_R2  = 16'h0008;
  localparam logic [15:0] GLIDER_R3  = 16'h000E;
  localparam logic [15:0] BLINKER_R7 = 16'h01C0;
  function automatic logic [15:0] pattern_row(input load_cfg_req_t cfg, input int row);
    return (cfg == CFG_1 && row == 1) ? GLIDER_R1 :
           (cfg == CFG_1 && row == 2) ? GLIDER_R2 :
           (cfg == CFG_1 && row == 3) ? GLIDER_R3 :
           (cfg == CFG_2 && row == 7) ? BLINKER_R7 : 16'h0000;
  endfunction
endpackage

// File: rtl/fcl_cfg_rom.sv
// fcl_cfg_rom: pattern row lookup with one cycle of read latency
module fcl_cfg_rom import defs::*; #(
  parameter int FIELD_W = defs::FIELD_W,
  parameter int FIELD_H = defs::FIELD_H
) (
  input  logic                       clk,
  input  load_cfg_req_t              cfg,
  input  logic [$clog2(FIELD_H)-1:0] row,
  output logic [FIELD_W-1:0]         data
);
  // registered read; unknown configs and rows outside a pattern read as empty
  always_ff @(posedge clk) data <= FIELD_W'(pattern_row(cfg, int'(row)));
endmodule

// File: rtl/fcl_loader.sv
// fcl_loader: streams a selected start pattern into field memory row by row
module fcl_loader import defs::*; #(
  parameter int FIELD_W = defs::FIELD_W,
  parameter int FIELD_H = defs::FIELD_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_go,
  input  load_cfg_req_t              i_cfg_req,
  input  logic                       i_wr_rdy,
  output logic                       o_is_loading,
  output logic                       o_we,
  output logic [$clog2(FIELD_H)-1:0] o_waddr,
  output logic [FIELD_W-1:0]         o_wdata,
  output logic                       o_done
);
  localparam int ROW_W = $clog2(FIELD_H);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(FIELD_H - 1);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  state_t state;
  load_cfg_req_t cfg, rom_cfg;
  logic [ROW_W-1:0] row, rom_row;
  logic [FIELD_W-1:0] rom_data;
  // ROM address tracks the row the FSM will be in after this edge
  always_comb begin
    rom_cfg = state == IDLE ? i_cfg_req : cfg;
    rom_row = state == IDLE ? '0 : state == WRITE ? row + ROW_W'(1) : row;
  end
  fcl_cfg_rom #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H)) u_rom (
    .clk  (clk),
    .cfg  (rom_cfg),
    .row  (rom_row),
    .data (rom_data)
  );
  // load sequencer with registered outputs; o_wdata doubles as the captured row
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      cfg          <= NO_REQ;
      row          <= '0;
      o_is_loading <= 1'b0;
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE:
          if (i_go && i_cfg_req != NO_REQ) begin
            cfg          <= i_cfg_req;
            row          <= '0;
            o_is_loading <= 1'b1;
            state        <= FETCH;
          end
        FETCH: begin
          o_we    <= 1'b1;
          o_waddr <= row;
          o_wdata <= rom_data;
          state   <= WRITE;
        end
        WRITE:
          if (i_wr_rdy) begin
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
            if (row == LAST) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              row   <= row + ROW_W'(1);
              state <= FETCH;
            end
          end
        default: begin
          o_is_loading <= 1'b0;
          cfg          <= NO_REQ;
          state        <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_fcl_loader.sv
// tb_fcl_loader: directed checks of pattern loads, stalls, ignored requests and reset abort
module tb_fcl_loader;
  import defs::*;
  logic clk = 0, rst_n = 0, i_go = 0, i_wr_rdy = 1;
  load_cfg_req_t i_cfg_req = NO_REQ;
  logic o_is_loading, o_we, o_done;
  logic [3:0] o_waddr;
  logic [15:0] o_wdata;
  int passed = 0, total = 0;
  logic prev_done = 0;

  fcl_loader dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_cfg_req(i_cfg_req), .i_wr_rdy(i_wr_rdy),
    .o_is_loading(o_is_loading), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {load_cfg_req_t cfg; int row; logic [15:0] wdata;} pat_t;
  pat_t pat [4];

  typedef struct {logic go; load_cfg_req_t cfg; logic exp_loading;} idle_vec_t;
  idle_vec_t iv [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_row(input load_cfg_req_t c, input int r);
    logic [15:0] v = 16'h0;
    for (int k = 0; k < 4; k++) if (pat[k].cfg == c && pat[k].row == r) v = pat[k].wdata;
    return v;
  endfunction

  always @(negedge clk) begin
    if (o_we) chk("we_implies_loading", {31'b0, o_is_loading}, 1);
    if (o_done) chk("done_is_pulse", {31'b0, prev_done}, 0);
    prev_done <= o_done;
  end

  task automatic run_load(input load_cfg_req_t c, input load_cfg_req_t exp_cfg, input int stall_row,
                          input int inject_row, input int abort_row,
                          output int nwr, output int done_cyc, output int ndone);
    int n = 0, stall_left = 3;
    logic injected = 0;
    logic [3:0] hold_a;
    logic [15:0] hold_d;
    nwr = 0; done_cyc = -1; ndone = 0;
    i_wr_rdy = 1;
    i_go = 1; i_cfg_req = c;
    forever begin
      @(negedge clk);
      n++;
      i_go = 0;
      if (n == 1) chk("loading_rises", {31'b0, o_is_loading}, 1);
      if (o_we) begin
        if (int'(o_waddr) == abort_row) begin
          #2 rst_n = 0;
          #1;
          chk("abort_we", {31'b0, o_we}, 0);
          chk("abort_loading", {31'b0, o_is_loading}, 0);
          chk("abort_waddr", {28'b0, o_waddr}, 0);
          chk("abort_wdata", {16'b0, o_wdata}, 0);
          return;
        end
        if (int'(o_waddr) == stall_row && stall_left > 0) begin
          if (stall_left == 3) begin hold_a = o_waddr; hold_d = o_wdata; end
          else begin
            chk("stall_waddr", {28'b0, o_waddr}, {28'b0, hold_a});
            chk("stall_wdata", {16'b0, o_wdata}, {16'b0, hold_d});
          end
          stall_left--;
          i_wr_rdy = 0;
        end else begin
          if (int'(o_waddr) == stall_row) chk("stall_released_data", {16'b0, o_wdata}, {16'b0, hold_d});
          i_wr_rdy = 1;
          chk("waddr_seq", {28'b0, o_waddr}, nwr);
          chk("wdata", {16'b0, o_wdata}, {16'b0, exp_row(exp_cfg, nwr)});
          nwr++;
        end
        if (int'(o_waddr) == inject_row && !injected) begin
          i_go = 1; i_cfg_req = CFG_2; injected = 1;
        end
      end else if (o_is_loading && !o_done) begin
        chk("wdata_zero_no_we", {16'b0, o_wdata}, 0);
      end
      if (o_done) begin ndone++; done_cyc = n; end
      if (!o_is_loading) return;
      if (n > 200) begin chk("load_timeout", n, 0); return; end
    end
  endtask

  int nwr, dc, nd;

  initial begin
    pat[0] = '{CFG_1, 1, 16'h0004};
    pat[1] = '{CFG_1, 2, 16'h0008};
    pat[2] = '{CFG_1, 3, 16'h000E};
    pat[3] = '{CFG_2, 7, 16'h01C0};
    iv[0] = '{1'b0, CFG_1,  1'b0};
    iv[1] = '{1'b1, NO_REQ, 1'b0};
    iv[2] = '{1'b0, CFG_2,  1'b0};
    iv[3] = '{1'b1, NO_REQ, 1'b0};
    iv[4] = '{1'b0, NO_REQ, 1'b0};

    #1;
    chk("rst_loading", {31'b0, o_is_loading}, 0);
    chk("rst_we", {31'b0, o_we}, 0);
    chk("rst_done", {31'b0, o_done}, 0);
    chk("rst_waddr", {28'b0, o_waddr}, 0);
    chk("rst_wdata", {16'b0, o_wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_go = iv[k].go; i_cfg_req = iv[k].cfg;
      repeat (2) begin
        @(negedge clk);
        i_go = 0;
        chk("noreq_loading", {31'b0, o_is_loading}, {31'b0, iv[k].exp_loading});
        chk("noreq_we", {31'b0, o_we}, 0);
        chk("noreq_done", {31'b0, o_done}, 0);
      end
    end

    @(negedge clk);
    run_load(CFG_1, CFG_1, -1, -1, -1, nwr, dc, nd);
    chk("cfg1_writes", nwr, 16);
    chk("cfg1_done_cycle", dc, 33);
    chk("cfg1_ndone", nd, 1);

    @(negedge clk);
    run_load(CFG_2, CFG_2, 7, -1, -1, nwr, dc, nd);
    chk("cfg2_stall_writes", nwr, 16);
    chk("cfg2_stall_done_cycle", dc, 36);
    chk("cfg2_stall_ndone", nd, 1);

    @(negedge clk);
    run_load(CFG_1, CFG_1, -1, 5, -1, nwr, dc, nd);
    chk("inject_writes", nwr, 16);
    chk("inject_ndone", nd, 1);
    chk("inject_done_cycle", dc, 33);

    @(negedge clk);
    run_load(CFG_1, CFG_1, -1, -1, 9, nwr, dc, nd);
    chk("abort_writes_before", nwr, 9);
    repeat (3) begin
      @(negedge clk);
      chk("in_reset_we", {31'b0, o_we}, 0);
      chk("in_reset_loading", {31'b0, o_is_loading}, 0);
    end
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_idle", {31'b0, o_is_loading}, 0);
    run_load(CFG_2, CFG_2, -1, -1, -1, nwr, dc, nd);
    chk("restart_writes", nwr, 16);
    chk("restart_done_cycle", dc, 33);
    chk("restart_ndone", nd, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
